// File: rtl/stream_cat_pkg.sv
// rtl/stream_cat_pkg.sv - shared constants, types and index helper for the stream concatenator
package stream_cat_pkg;

    // Upper bound on the number of lanes a single concatenator may carry.
    localparam int MAX_LINKS = 32;

    // Lane-enable / lane-status mask sized for the largest configuration.
    typedef logic [MAX_LINKS-1:0] lane_mask_t;

    // Low bit index of lane `lane` inside a packed bus of `width`-bit words.
    function automatic int lane_slice(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/stream_cat_lane_fifo.sv
// rtl/stream_cat_lane_fifo.sv - per-lane show-ahead elastic FIFO
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write strobe and word (caller guarantees !full)
//   pop          read strobe (caller guarantees !empty)
//   flush        synchronous clear to empty; dominates push/pop
//   dout         word at the head, valid whenever !empty
//   empty, full  registered occupancy flags
module stream_cat_lane_fifo
    import stream_cat_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    // Flags come straight from the registered count, so a word pushed into
    // an empty FIFO only becomes visible on the following cycle.
    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so they wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stream_cat_aligned.sv
// rtl/stream_cat_aligned.sv - aligns N_LINKS skewed lanes into one wide handshaked stream
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   s_axis_*         per-lane input streams, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_*         concatenated output stream, lane 0 in the LSBs
//   lane_enable      per-lane participation mask; disabled lanes sink data, emit zeros
//   skew_err_clr     pulse clearing skew_err
//   skew_err         sticky: one enabled lane full while another enabled lane empty
//   beat_count       number of output beats transferred, wrapping
module stream_cat_aligned
    import stream_cat_pkg::*;
#(
    parameter int N_LINKS    = 12,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_LINKS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_LINKS-1:0]            s_axis_tvalid,
    output logic [N_LINKS-1:0]            s_axis_tready,
    output logic [N_LINKS*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic [N_LINKS-1:0]            lane_enable,
    input  logic                          skew_err_clr,
    output logic                          skew_err,
    output logic [CNT_WIDTH-1:0]          beat_count
);

    logic [N_LINKS-1:0]            fifo_empty;
    logic [N_LINKS-1:0]            fifo_full;
    logic [N_LINKS-1:0]            push;
    logic [N_LINKS-1:0]            pop;
    logic [N_LINKS*DATA_WIDTH-1:0] fifo_dout;
    logic [N_LINKS*DATA_WIDTH-1:0] load_data;
    logic                          all_rdy;
    logic                          load;
    logic                          skew_set;

    for (genvar i = 0; i < N_LINKS; i++) begin : g_lane
        localparam int LO = lane_slice(i, DATA_WIDTH);

        // Ready depends only on registered state and inputs: no path from
        // m_axis_tready through the pop back to s_axis_tready.
        assign s_axis_tready[i] = !rst && (!lane_enable[i] || !fifo_full[i]);
        assign push[i]          = s_axis_tvalid[i] && lane_enable[i] && !fifo_full[i];
        assign pop[i]           = load && lane_enable[i];
        assign load_data[LO +: DATA_WIDTH] =
            lane_enable[i] ? fifo_dout[LO +: DATA_WIDTH] : '0;

        // Holding flush while disabled empties the lane on the first edge
        // after disable and keeps it empty until re-enabled.
        stream_cat_lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .din   (s_axis_tdata[LO +: DATA_WIDTH]),
            .pop   (pop[i]),
            .flush (!lane_enable[i]),
            .dout  (fifo_dout[LO +: DATA_WIDTH]),
            .empty (fifo_empty[i]),
            .full  (fifo_full[i])
        );
    end

    assign all_rdy  = (&(~lane_enable | ~fifo_empty)) && (|lane_enable);
    assign load     = all_rdy && (!m_axis_tvalid || m_axis_tready);
    assign skew_set = (|(lane_enable & fifo_full)) && (|(lane_enable & fifo_empty));

    // Output register: only reloads when empty or being consumed, so a
    // stalled beat stays untouched even if lane_enable changes meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= load_data;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Set dominates a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skew_err <= 1'b0;
        end else if (skew_set) begin
            skew_err <= 1'b1;
        end else if (skew_err_clr) begin
            skew_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count <= '0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            beat_count <= beat_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_stream_cat_aligned.sv
// tb/tb_stream_cat_aligned.sv - scoreboard bench for stream_cat_aligned (4 lanes x 8 bits, depth 8)
module tb_stream_cat_aligned;

    localparam int NL = 4;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NL*DW-1:0] s_tdata;
    logic [NL-1:0]    s_tvalid;
    logic [NL-1:0]    s_tready;
    logic [NL*DW-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic [NL-1:0]    lane_enable;
    logic             skew_err_clr;
    logic             skew_err;
    logic [31:0]      beat_count;

    logic [7:0]       lane_q [NL][$];
    logic [31:0]      exp_q[$];
    logic [NL-1:0]    gate;
    int               exp_beats = 0;
    int               vectors   = 0;
    int               errors    = 0;

    stream_cat_aligned #(
        .N_LINKS    (NL),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (8),
        .CNT_WIDTH  (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .lane_enable   (lane_enable),
        .skew_err_clr  (skew_err_clr),
        .skew_err      (skew_err),
        .beat_count    (beat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lv(input int i, input int k, input int off);
        return 8'(i * 16 + k + off);
    endfunction

    // Queue nk words per lane in `mask` and the matching expected beats
    // (lanes outside `mask` contribute zero).
    task automatic send(input int nk, input int off, input logic [NL-1:0] mask);
        logic [31:0] b;
        for (int k = 0; k < nk; k++) begin
            b = '0;
            for (int i = 0; i < NL; i++) begin
                if (mask[i]) begin
                    lane_q[i].push_back(lv(i, k, off));
                    b[i*DW +: DW] = lv(i, k, off);
                end
            end
            exp_q.push_back(b);
            exp_beats++;
        end
    endtask

    // Handshake seen this cycle is computed before the edge; new inputs
    // are driven 1 time unit after the edge.
    task automatic step();
        logic [NL-1:0] fire;
        fire = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++) begin
            if (fire[i] && lane_q[i].size() > 0) begin
                void'(lane_q[i].pop_front());
            end
            if (gate[i] && lane_q[i].size() > 0) begin
                s_tvalid[i]          = 1'b1;
                s_tdata[i*DW +: DW]  = lane_q[i][0];
            end else begin
                s_tvalid[i] = 1'b0;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || lane_q[0].size() != 0 || lane_q[1].size() != 0 ||
                lane_q[2].size() != 0 || lane_q[3].size() != 0) && n < 300) begin
            step();
            n++;
        end
        chk({tag, "_drain_done"}, 32'(n < 300), 32'd1);
        step();
        step();
        chk({tag, "_beat_count"}, beat_count, 32'(exp_beats));
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks
    // that a stalled beat is held unchanged.
    logic        stall_prev = 1'b0;
    logic [31:0] held;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_tvalid", 32'(m_tvalid), 32'd1);
                chk("hold_tdata", m_tdata, held);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", m_tdata, 32'hxxxxxxxx);
                end else begin
                    chk("beat_data", m_tdata, exp_q.pop_front());
                end
            end
            stall_prev = m_tvalid && !m_tready;
            held       = m_tdata;
        end
    end

    initial begin
        rst          = 1'b1;
        s_tdata      = '0;
        s_tvalid     = '0;
        m_tready     = 1'b1;
        lane_enable  = 4'hF;
        skew_err_clr = 1'b0;
        gate         = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_skew", 32'(skew_err), 32'd0);
        chk("rst_count", beat_count, 32'd0);
        rst = 1'b0;

        // 1: aligned streaming, latency and 1 beat/clk
        send(8, 0, 4'hF);
        step();
        step();
        chk("t1_no_valid_yet", 32'(m_tvalid), 32'd0);
        step();
        chk("t1_first_valid", 32'(m_tvalid), 32'd1);
        chk("t1_first_data", m_tdata, 32'h30201000);
        repeat (8) step();
        chk("t1_count_8", beat_count, 32'd8);
        chk("t1_idle", 32'(m_tvalid), 32'd0);
        drain("t1");

        // 2: lane 2 skewed by 5 clk
        gate = 4'b1011;
        send(6, 8, 4'hF);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t2_wait_lane2", 32'(m_tvalid), 32'd0);
        end
        gate = 4'hF;
        drain("t2");
        chk("t2_skew_clear", 32'(skew_err), 32'd0);

        // 3: lane 1 idle while the others fill up
        gate = 4'b1101;
        send(8, 8'h80, 4'hF);
        repeat (12) step();
        chk("t3_lane0_full", 32'(s_tready[0]), 32'd0);
        chk("t3_lane1_ready", 32'(s_tready[1]), 32'd1);
        chk("t3_skew_set", 32'(skew_err), 32'd1);
        chk("t3_no_beat", 32'(m_tvalid), 32'd0);
        gate = 4'hF;
        drain("t3");
        chk("t3_skew_sticky", 32'(skew_err), 32'd1);
        skew_err_clr = 1'b1;
        step();
        skew_err_clr = 1'b0;
        chk("t3_skew_cleared", 32'(skew_err), 32'd0);

        // 4: output back-pressure for 10 clk
        send(16, 0, 4'hF);
        repeat (4) step();
        m_tready = 1'b0;
        repeat (10) step();
        m_tready = 1'b1;
        drain("t4");

        // 5: disable lane 2 mid-stream holding stray words, then re-enable
        send(4, 8'h20, 4'hF);
        drain("t5a");
        for (int j = 0; j < 3; j++) lane_q[2].push_back(8'hE0 + 8'(j));
        repeat (5) step();
        chk("t5_lane2_alone", 32'(m_tvalid), 32'd0);
        lane_enable = 4'b1011;
        step();
        chk("t5_lane2_ready", 32'(s_tready[2]), 32'd1);
        for (int j = 0; j < 3; j++) lane_q[2].push_back(8'hD0 + 8'(j));
        send(4, 8'h30, 4'b1011);
        drain("t5b");
        lane_enable = 4'hF;
        send(2, 8'h50, 4'hF);
        drain("t5c");

        // 6: reset with a pending beat and 3 words buffered per lane
        m_tready = 1'b0;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < NL; i++) lane_q[i].push_back(lv(i, k, 8'h70));
        repeat (8) step();
        chk("t6_pending", 32'(m_tvalid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_tvalid", 32'(m_tvalid), 32'd0);
        chk("t6_async_tdata", m_tdata, 32'd0);
        chk("t6_async_count", beat_count, 32'd0);
        chk("t6_async_tready", 32'(s_tready), 32'd0);
        for (int i = 0; i < NL; i++) lane_q[i].delete();
        s_tvalid  = '0;
        exp_beats = 0;
        step();
        step();
        rst      = 1'b0;
        m_tready = 1'b1;
        send(2, 8'h60, 4'hF);
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
